// File: rtl/fifo_fill_ctrl_if.sv
// fifo_fill_ctrl_if: producer-controller to downstream FIFO signal bundle.
interface fifo_fill_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              enable;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_words;
  logic              wr_en;
  logic [DATA_W-1:0] fifo_data;
  logic [1:0]        state_o;
  logic [15:0]       wr_count;
  modport master (input enable, fifo_full, fifo_words, output wr_en, fifo_data, state_o, wr_count);
  modport slave  (output enable, fifo_full, fifo_words, input wr_en, fifo_data, state_o, wr_count);
endinterface

// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: FIFO producer with watermark hysteresis, full gating and a saturating write counter.
module fifo_fill_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                CNT_W       = 4,
  parameter int                HIGH_MARK   = 5,
  parameter int                LOW_MARK    = 2,
  parameter logic [DATA_W-1:0] PATTERN     = 8'hAA,
  parameter int                MODE        = 0,
  parameter int                WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  fifo_fill_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITING, WAIT_STOP, WAIT_DRAIN} state_t;
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HI = CNT_W'(HIGH_MARK);
  localparam logic [CNT_W-1:0] LO = CNT_W'(LOW_MARK);
  localparam logic [WW-1:0] WLOAD = WW'(WAIT_CYCLES - 1);
  state_t state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [DATA_W-1:0] data;
  logic [15:0] cnt;
  logic at_high;
  assign at_high = bus.fifo_words >= HI;
  // Gating on the live count keeps the write from overshooting HIGH_MARK.
  assign bus.wr_en = (state == WRITING) && !bus.fifo_full && !at_high;
  assign bus.fifo_data = data;
  assign bus.state_o = state;
  assign bus.wr_count = cnt;
  always_comb begin
    state_nx = state;
    wcnt_nx = wcnt;
    if (!bus.enable) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = WRITING;
        WRITING:
          if (at_high) begin
            state_nx = WAIT_STOP;
            wcnt_nx = WLOAD;
          end
        WAIT_STOP:
          if (wcnt == '0) state_nx = WAIT_DRAIN;
          else wcnt_nx = wcnt - 1'b1;
        WAIT_DRAIN: state_nx = (bus.fifo_words <= LO) ? WRITING : WAIT_DRAIN;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      data <= PATTERN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
      if (bus.wr_en) begin
        data <= data + DATA_W'(MODE == 1);
        cnt <= cnt + 16'(cnt != 16'hFFFF);
      end
    end
  end
endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// tb_fifo_fill_ctrl: two controller instances against a cycle-level behavioural model and FIFO occupancy model.
module tb_fifo_fill_ctrl;
  localparam int HI = 5, LO = 2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  fifo_fill_ctrl_if #(.DATA_W(8), .CNT_W(4)) f0 ();
  fifo_fill_ctrl_if #(.DATA_W(8), .CNT_W(4)) f1 ();
  fifo_fill_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(f0.master));
  fifo_fill_ctrl #(.PATTERN(8'hFE), .MODE(1), .WAIT_CYCLES(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1.master));
  logic en [2], full [2], rd [2];
  int occ [2];
  assign f0.enable = en[0];
  assign f0.fifo_full = full[0];
  assign f0.fifo_words = 4'(occ[0]);
  assign f1.enable = en[1];
  assign f1.fifo_full = full[1];
  assign f1.fifo_words = 4'(occ[1]);
  logic wr [2];
  logic [7:0] dat [2];
  logic [1:0] st [2];
  logic [15:0] wc [2];
  assign wr[0] = f0.wr_en;
  assign dat[0] = f0.fifo_data;
  assign st[0] = f0.state_o;
  assign wc[0] = f0.wr_count;
  assign wr[1] = f1.wr_en;
  assign dat[1] = f1.fifo_data;
  assign st[1] = f1.state_o;
  assign wc[1] = f1.wr_count;
  // Model phases: 0 idle, 1 filling, 2 settling, 3 draining.
  int ms [2], mleft [2], mc [2];
  logic [7:0] md [2];
  logic [7:0] pat [2] = '{8'hAA, 8'hFE};
  int mode [2] = '{0, 1};
  int wcyc [2] = '{1, 3};
  int tests = 0, fails = 0;

  function automatic logic exp_wr(int i);
    return ms[i] == 1 && !full[i] && occ[i] < HI;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = 0; mleft[i] = 0; mc[i] = 0; md[i] = pat[i];
      occ[i] = 0; en[i] = 0; full[i] = 0; rd[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    logic acc;
    int nxt;
    acc = exp_wr(i);
    nxt = ms[i];
    if (!en[i]) nxt = 0;
    else if (ms[i] == 0) nxt = 1;
    else if (ms[i] == 1 && occ[i] >= HI) begin nxt = 2; mleft[i] = wcyc[i]; end
    else if (ms[i] == 2) begin mleft[i]--; if (mleft[i] == 0) nxt = 3; end
    else if (ms[i] == 3 && occ[i] <= LO) nxt = 1;
    if (acc) begin
      md[i] = md[i] + 8'(mode[i]);
      if (mc[i] < 65535) mc[i]++;
    end
    occ[i] = occ[i] + int'(acc) - ((rd[i] && occ[i] > 0) ? 1 : 0);
    ms[i] = nxt;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (wr[i] !== 1'b0 || dat[i] !== pat[i] || wc[i] !== 16'd0 || st[i] !== 2'd0) begin
        fails++;
        $display("FAIL reset dut%0d: wr=%b dat=%h cnt=%0d st=%0d expected 0 %h 0 0", i, wr[i], dat[i], wc[i], st[i], pat[i]);
      end
    end
    rst_n = 1;
  endtask

  task automatic test_fill();
    int pulses = 0, stops = 0;
    en[0] = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      tests++;
      if (wr[0] !== exp_wr(0) || st[0] !== 2'(ms[0]) || dat[0] !== md[0] || wc[0] !== 16'(mc[0])) begin
        fails++;
        $display("FAIL fill_cyc%0d: wr=%b st=%0d dat=%h cnt=%0d expected %b %0d %h %0d", c, wr[0], st[0], dat[0], wc[0], exp_wr(0), ms[0], md[0], mc[0]);
      end
      if (wr[0]) pulses++;
      if (st[0] == 2'd2) stops++;
    end
    tests++;
    if (pulses != 5 || wc[0] !== 16'd5 || st[0] !== 2'd3 || f0.fifo_words !== 4'd5 || stops != 1) begin
      fails++;
      $display("FAIL fill_end: pulses=%0d cnt=%0d st=%0d words=%0d stops=%0d expected 5 5 3 5 1", pulses, wc[0], st[0], f0.fifo_words, stops);
    end
  endtask

  task automatic test_drain();
    int writes = 0;
    rd[0] = 1;
    for (int c = 0; c < 10 && occ[0] > LO; c++) begin
      @(negedge clk);
      tests++;
      if (wr[0] !== 1'b0 || st[0] !== 2'd3) begin
        fails++;
        $display("FAIL drain_hold words=%0d: wr=%b st=%0d expected 0 3", occ[0], wr[0], st[0]);
      end
    end
    rd[0] = 0;
    tests++;
    if (st[0] !== 2'd3 || f0.fifo_words !== 4'd2) begin
      fails++;
      $display("FAIL drain_low: st=%0d words=%0d expected 3 2", st[0], f0.fifo_words);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (st[0] !== 2'd1) begin
          fails++;
          $display("FAIL drain_resume: st=%0d expected 1", st[0]);
        end
      end
      tests++;
      if (wr[0] !== exp_wr(0) || st[0] !== 2'(ms[0]) || wc[0] !== 16'(mc[0])) begin
        fails++;
        $display("FAIL refill_cyc%0d: wr=%b st=%0d cnt=%0d expected %b %0d %0d", c, wr[0], st[0], wc[0], exp_wr(0), ms[0], mc[0]);
      end
      if (wr[0]) writes++;
    end
    tests++;
    if (writes != 3 || f0.fifo_words !== 4'd5) begin
      fails++;
      $display("FAIL refill_end: writes=%0d words=%0d expected 3 5", writes, f0.fifo_words);
    end
  endtask

  task automatic test_full();
    logic [7:0] d0;
    logic [15:0] w0;
    en[0] = 0;
    rd[0] = 1;
    for (int c = 0; c < 10 && occ[0] > 1; c++) @(negedge clk);
    rd[0] = 0;
    en[0] = 1;
    @(negedge clk);
    tests++;
    if (st[0] !== 2'd1 || wr[0] !== 1'b1) begin
      fails++;
      $display("FAIL full_pre: st=%0d wr=%b expected 1 1", st[0], wr[0]);
    end
    d0 = md[0];
    w0 = 16'(mc[0]);
    full[0] = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (wr[0] !== 1'b0 || st[0] !== 2'd1 || dat[0] !== d0 || wc[0] !== w0) begin
        fails++;
        $display("FAIL full_cyc%0d: wr=%b st=%0d dat=%h cnt=%0d expected 0 1 %h %0d", c, wr[0], st[0], dat[0], wc[0], d0, w0);
      end
    end
    full[0] = 0;
    #1;
    tests++;
    if (wr[0] !== 1'b1 || wc[0] !== w0) begin
      fails++;
      $display("FAIL full_release: wr=%b cnt=%0d expected 1 %0d", wr[0], wc[0], w0);
    end
  endtask

  task automatic test_disable();
    for (int c = 0; c < 20 && ms[0] != 3; c++) @(negedge clk);
    tests++;
    if (st[0] !== 2'd3) begin
      fails++;
      $display("FAIL disable_pre: st=%0d expected 3", st[0]);
    end
    en[0] = 0;
    @(negedge clk);
    tests++;
    if (st[0] !== 2'd0 || wr[0] !== 1'b0) begin
      fails++;
      $display("FAIL disable: st=%0d wr=%b expected 0 0", st[0], wr[0]);
    end
  endtask

  task automatic test_async_reset();
    rd[0] = 1;
    for (int c = 0; c < 10 && occ[0] > 3; c++) @(negedge clk);
    rd[0] = 0;
    en[0] = 1;
    @(negedge clk);
    tests++;
    if (st[0] !== 2'd1 || wr[0] !== 1'b1) begin
      fails++;
      $display("FAIL reenable_mid: st=%0d wr=%b expected 1 1", st[0], wr[0]);
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (wr[0] !== 1'b0 || st[0] !== 2'd0 || wc[0] !== 16'd0 || dat[0] !== 8'hAA || dat[1] !== 8'hFE) begin
      fails++;
      $display("FAIL async_reset: wr=%b st=%0d cnt=%0d dat0=%h dat1=%h expected 0 0 0 aa fe", wr[0], st[0], wc[0], dat[0], dat[1]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_pattern();
    logic [7:0] pexp [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    int k = 0, stops = 0;
    en[1] = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if (wr[1] !== exp_wr(1) || st[1] !== 2'(ms[1]) || dat[1] !== md[1] || wc[1] !== 16'(mc[1])) begin
        fails++;
        $display("FAIL pattern_cyc%0d: wr=%b st=%0d dat=%h cnt=%0d expected %b %0d %h %0d", c, wr[1], st[1], dat[1], wc[1], exp_wr(1), ms[1], md[1], mc[1]);
      end
      if (wr[1]) begin
        tests++;
        if (k >= 5 || dat[1] !== pexp[k]) begin
          fails++;
          $display("FAIL pattern_word%0d: dat=%h expected %h", k, dat[1], (k < 5) ? pexp[k] : 8'hxx);
        end
        k++;
      end
      if (st[1] == 2'd2) stops++;
    end
    tests++;
    if (k != 5 || wc[1] !== 16'd5 || stops != 3) begin
      fails++;
      $display("FAIL pattern_end: writes=%0d cnt=%0d stop_cycles=%0d expected 5 5 3", k, wc[1], stops);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (wr[i] !== exp_wr(i) || st[i] !== 2'(ms[i]) || dat[i] !== md[i] || wc[i] !== 16'(mc[i])) begin
          fails++;
          $display("FAIL random_cyc%0d dut%0d: wr=%b st=%0d dat=%h cnt=%0d expected %b %0d %h %0d", c, i, wr[i], st[i], dat[i], wc[i], exp_wr(i), ms[i], md[i], mc[i]);
        end
        en[i] = $urandom_range(0, 15) != 0;
        full[i] = $urandom_range(0, 4) == 0;
        rd[i] = $urandom_range(0, 9) < 4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full();
    test_disable();
    test_async_reset();
    test_pattern();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
